// File: rtl/pfpu_dma.sv
// pfpu_dma: PFPU write-back stage; queues {a,b,y,x} results and writes each as a 2-beat Wishbone burst.
// Latency: push in cycle N -> dma_busy at N+1, cyc/stb at N+2; zero-wait entry holds the bus 2 cycles, 3-cycle minimum period.
// Backpressure: dma_ack drops when the FIFO is full; a push while full is dropped and sets sticky overflow.
// Ports: sys_clk/sys_rst_n (async active-low); dma_base/x/y/a/b/dma_en in, dma_ack/dma_busy/overflow/dma_count out;
//        wbm_* Wishbone master write port (sel=4'hf, we=1 constant).
module pfpu_dma #(
  parameter int DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [28:0] dma_base,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        dma_en,
  output logic        dma_ack,
  output logic        dma_busy,
  output logic        overflow,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic [31:0] dma_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  y;
    logic [6:0]  x;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [2:0]      cti_q, cti_d;
  logic [31:0]     dma_count_q;
  logic            overflow_q;

  logic            push, pop;
  entry_t          head;
  entry_t          wr_entry;
  logic [28:0]     head_w;

  // Acceptance looks only at the registered count, so a pop in the same
  // cycle never opens a slot early.
  assign dma_ack  = (count_q < FULL);
  assign dma_busy = (count_q != '0) | cyc_q;
  assign push     = dma_en & dma_ack;

  assign head     = mem_q[rd_ptr_q];
  assign wr_entry = '{a: a, b: b, y: y, x: x};
  // {y,x} is the 14-bit linear mesh index; the sum wraps at 29 bits.
  assign head_w   = dma_base + {15'd0, head.y, head.x};

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cti_d   = cti_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = BEAT0;
          cyc_d   = 1'b1;
          adr_d   = {head_w, 3'b000};
          dat_d   = head.a;
          cti_d   = CTI_INCR;
        end
      end
      BEAT0: begin
        if (wbm_ack_i) begin
          state_d = BEAT1;
          adr_d   = {head_w, 3'b100};
          dat_d   = head.b;
          cti_d   = CTI_END;
        end
      end
      BEAT1: begin
        if (wbm_ack_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          pop     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      cti_q       <= '0;
      dma_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        dma_count_q <= dma_count_q + 32'd1;
      end
      if (dma_en && !dma_ack) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cti_q   <= cti_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = 4'hf;
  assign wbm_cti_o = cti_q;
  assign wbm_we_o  = 1'b1;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign dma_count = dma_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pfpu_dma.sv
// tb_pfpu_dma: randomized and directed bench for pfpu_dma with a queue scoreboard.
// Stimulus pushes expected bursts into a queue; a negedge monitor pops and compares accepted beats.
// Ack driver modes: 0 random 0..3 wait states, 1 tied high, 3 manual (driven by the stimulus).
`timescale 1ns/1ps
module tb_pfpu_dma;
  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [28:0] dma_base;
  logic [6:0]  x, y;
  logic [31:0] a, b;
  logic        dma_en;
  logic        dma_ack, dma_busy, overflow;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic        wbm_ack_i;
  logic [31:0] dma_count;

  pfpu_dma #(.DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dma_base(dma_base),
    .x(x), .y(y), .a(a), .b(b), .dma_en(dma_en),
    .dma_ack(dma_ack), .dma_busy(dma_busy), .overflow(overflow),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cti_o(wbm_cti_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .dma_count(dma_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] adr0;
    logic [31:0] dat0;
    logic [31:0] adr1;
    logic [31:0] dat1;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;
  int   pushed  = 0;   // entries the model says were accepted since reset
  int   popped  = 0;   // entries whose second beat was acked since reset
  int   ack_mode = 3;
  int   mon_beat = 0;
  bit   gap_pending = 1'b0;
  int   wl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination byte address from the mesh rule: word = (base + y*128 + x) mod 2^29.
  function automatic logic [31:0] byte_addr(input logic [28:0] base, input logic [6:0] xx,
                                            input logic [6:0] yy, input int beat);
    longint w;
    w = (longint'(base) + longint'(yy) * 128 + longint'(xx)) % (longint'(1) << 29);
    return 32'(w * 8 + longint'(beat) * 4);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; the push resolves at the next edge.
  task automatic push_entry(input logic [6:0] xx, input logic [6:0] yy,
                            input logic [31:0] aa, input logic [31:0] bb);
    bit exp_ack;
    x = xx; y = yy; a = aa; b = bb;
    dma_en = 1'b1;
    exp_ack = (pushed - popped) < DEPTH;
    check("dma_ack", dma_ack, exp_ack);
    if (exp_ack)
      sbq.push_back('{byte_addr(dma_base, xx, yy, 0), aa, byte_addr(dma_base, xx, yy, 1), bb});
    @(posedge sys_clk);
    if (exp_ack) pushed++;
    #1;
    dma_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || wbm_cyc_o) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 3000, 1'b1);
  endtask

  // Ack driver.
  initial begin
    wbm_ack_i = 1'b0;
    wl = -1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (ack_mode)
        1: wbm_ack_i = 1'b1;
        0: begin
          if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
            wl = -1;
          end
          if (wbm_cyc_o && wbm_stb_o) begin
            if (wl < 0) wl = int'($urandom_range(0, 3));
            if (wl == 0) wbm_ack_i = 1'b1;
            else wl--;
          end
        end
        default: ;
      endcase
    end
  end

  // Monitor: every acked beat is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        mon_beat = 0;
        gap_pending = 1'b0;
      end else begin
        if (gap_pending) begin
          check("cyc_gap", wbm_cyc_o, 1'b0);
          gap_pending = 1'b0;
        end
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
          if (sbq.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_beat: adr %h dat %h with empty scoreboard", wbm_adr_o, wbm_dat_o);
          end else if (mon_beat == 0) begin
            check("beat0_adr", wbm_adr_o, sbq[0].adr0);
            check("beat0_dat", wbm_dat_o, sbq[0].dat0);
            check("beat0_cti", wbm_cti_o, 3'b010);
            check("sel", wbm_sel_o, 4'hf);
            check("we", wbm_we_o, 1'b1);
            mon_beat = 1;
          end else begin
            check("beat1_adr", wbm_adr_o, sbq[0].adr1);
            check("beat1_dat", wbm_dat_o, sbq[0].dat1);
            check("beat1_cti", wbm_cti_o, 3'b111);
            void'(sbq.pop_front());
            popped++;
            mon_beat = 0;
            gap_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    sys_rst_n = 1'b0;
    dma_en = 1'b0;
    dma_base = '0;
    x = '0; y = '0; a = '0; b = '0;
    repeat (3) @(posedge sys_clk);
    #1;

    // Reset state
    check("rst_cyc", wbm_cyc_o, 1'b0);
    check("rst_stb", wbm_stb_o, 1'b0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_dat", wbm_dat_o, 32'h0);
    check("rst_cti", wbm_cti_o, 3'b000);
    check("rst_ack", dma_ack, 1'b1);
    check("rst_busy", dma_busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_count", dma_count, 32'h0);
    sys_rst_n = 1'b1;
    tick();

    // Single push, ack tied high: check cycle-by-cycle latency.
    ack_mode = 1;
    dma_base = 29'h100;
    push_entry(7'd3, 7'd2, 32'h11111111, 32'h22222222);
    check("n1_busy", dma_busy, 1'b1);
    check("n1_cyc", wbm_cyc_o, 1'b0);
    tick();
    check("n2_cyc", wbm_cyc_o, 1'b1);
    check("n2_adr", wbm_adr_o, byte_addr(29'h100, 7'd3, 7'd2, 0));
    check("n2_cti", wbm_cti_o, 3'b010);
    tick();
    check("n3_cyc", wbm_cyc_o, 1'b1);
    check("n3_adr", wbm_adr_o, byte_addr(29'h100, 7'd3, 7'd2, 1));
    check("n3_dat", wbm_dat_o, 32'h22222222);
    tick();
    check("m1_cyc", wbm_cyc_o, 1'b0);
    check("m1_busy", dma_busy, 1'b0);
    check("m1_count", dma_count, 32'd1);

    // Address wrap at 2^29 words.
    dma_base = 29'h1FFFFFFF;
    push_entry(7'd1, 7'd0, $urandom, $urandom);
    drain();

    // Fill with ack held low, then overflow.
    ack_mode = 3;
    wbm_ack_i = 1'b0;
    dma_base = 29'($urandom);
    for (int i = 0; i < DEPTH; i++) push_entry(7'(i), 7'(i + 1), $urandom, $urandom);
    check("full_ack", dma_ack, (pushed - popped) < DEPTH);
    check("ovf_before", overflow, 1'b0);
    push_entry(7'd9, 7'd9, 32'hDEADBEEF, 32'hBADC0DE5);
    check("ovf_after", overflow, 1'b1);
    ack_mode = 0;
    drain();
    check("count_after_full", dma_count, 32'(pushed));

    // Push and pop in the same cycle at count=2.
    ack_mode = 3;
    wbm_ack_i = 1'b0;
    push_entry(7'd10, 7'd20, $urandom, $urandom);
    push_entry(7'd11, 7'd21, $urandom, $urandom);
    check("pp_cyc", wbm_cyc_o, 1'b1);
    wbm_ack_i = 1'b1;
    tick();
    push_entry(7'd12, 7'd22, $urandom, $urandom);
    wbm_ack_i = 1'b0;
    check("pp_idle", wbm_cyc_o, 1'b0);
    push_entry(7'd13, 7'd23, $urandom, $urandom);
    push_entry(7'd14, 7'd24, $urandom, $urandom);
    check("pp_full", dma_ack, (pushed - popped) < DEPTH);
    ack_mode = 0;
    drain();

    // 64 entries, random wait states, x/y sweep.
    dma_base = 29'($urandom);
    for (int i = 0; i < 64; i++) begin
      n = 0;
      while ((pushed - popped) >= DEPTH && n < 200) begin
        tick();
        n++;
      end
      repeat ($urandom_range(0, 2)) tick();
      push_entry(7'(i % 8), 7'(i / 8), $urandom, $urandom);
    end
    drain();
    check("rand_count", dma_count, 32'(pushed));
    check("rand_busy", dma_busy, 1'b0);
    check("rand_ack", dma_ack, 1'b1);

    // Reset during beat 1 with 3 entries queued.
    ack_mode = 3;
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) push_entry(7'(i), 7'(5), $urandom, $urandom);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("b1_cti", wbm_cti_o, 3'b111);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_cyc", wbm_cyc_o, 1'b0);
    check("arst_stb", wbm_stb_o, 1'b0);
    sbq.delete();
    pushed = 0;
    popped = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    check("post_busy", dma_busy, 1'b0);
    check("post_ack", dma_ack, 1'b1);
    check("post_count", dma_count, 32'h0);
    check("post_ovf", overflow, 1'b0);
    ack_mode = 1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (wbm_cyc_o) seen = 1'b1;
    end
    check("post_idle", seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
